// File: rtl/cpu_nios_debug_jtag_host.sv
// Virtual-JTAG initiator: walks UIR -> CDR -> SDR x DR_WIDTH -> E1DR per command,
// driving a divided tck/tdi and returning captured tdo bits plus the target's ir_out.
module cpu_nios_debug_jtag_host #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [1:0]          ir_in,
    input  logic [1:0]          ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_e1dr,
    output logic                jtag_state_rti
);

    localparam int unsigned HW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int unsigned BW = $clog2(DR_WIDTH);
    localparam logic [HW-1:0] HLAST = HW'(TCK_DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, E1DR} state_t;

    state_t              state, state_next;
    logic [HW-1:0]       hcnt;
    logic [BW-1:0]       bitcnt;
    logic [DR_WIDTH-1:0] txsr, txsr_next, rxsr;
    logic [1:0]          ir_cap;
    logic                accept, half_end, rise, period_end, tdi_next;

    always_comb begin
        accept     = (state == IDLE) && cmd_valid;
        half_end   = (state != IDLE) && (hcnt == HLAST);
        rise       = half_end && !tck;
        period_end = half_end && tck;

        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = UIR;
            UIR:     if (period_end) state_next = CDR;
            CDR:     if (period_end) state_next = SDR;
            SDR:     if (period_end && bitcnt == BLAST) state_next = E1DR;
            E1DR:    if (period_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        txsr_next = txsr;
        if (accept)
            txsr_next = cmd_dr;
        else if (state == SDR && period_end)
            txsr_next = {1'b0, txsr[DR_WIDTH-1:1]};

        // tdi is registered from the upcoming state/shift value so it moves only at period start
        tdi_next = (state_next == CDR || state_next == SDR) ? txsr_next[0] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt      <= '0;
            bitcnt    <= '0;
            tck       <= 1'b0;
            tdi       <= 1'b0;
            txsr      <= '0;
            rxsr      <= '0;
            ir_cap    <= '0;
            ir_in     <= '0;
            rsp_valid <= 1'b0;
            rsp_dr    <= '0;
            rsp_ir    <= '0;
        end else begin
            tdi       <= tdi_next;
            txsr      <= txsr_next;
            rsp_valid <= 1'b0;

            if (state == IDLE) begin
                hcnt <= '0;
                tck  <= 1'b0;
            end else if (half_end) begin
                hcnt <= '0;
                tck  <= ~tck;
            end else begin
                hcnt <= hcnt + 1'b1;
            end

            if (accept) begin
                ir_in <= cmd_ir;
                rxsr  <= '0;
            end

            if (rise && state == UIR) ir_cap <= ir_out;
            if (rise && state == SDR) rxsr <= {tdo, rxsr[DR_WIDTH-1:1]};

            if (period_end && state == CDR) bitcnt <= '0;
            if (period_end && state == SDR) bitcnt <= bitcnt + 1'b1;

            if (period_end && state == E1DR) begin
                rsp_valid <= 1'b1;
                rsp_dr    <= rxsr;
                rsp_ir    <= ir_cap;
            end
        end
    end

    assign cmd_ready      = (state == IDLE);
    assign jtag_state_rti = (state == IDLE);
    assign vs_uir         = (state == UIR);
    assign vs_cdr         = (state == CDR);
    assign vs_sdr         = (state == SDR);
    assign vs_e1dr        = (state == E1DR);

endmodule

// File: tb/tb_cpu_nios_debug_jtag_host.sv
// Scoreboard bench: loopback targets on two configurations; driver pushes expected
// responses derived from target contents, a monitor pops them on rsp_valid.
module tb_cpu_nios_debug_jtag_host;

    localparam int W    = 38;
    localparam int D    = 2;
    localparam int LAT  = 1 + (W + 3) * 2 * D;
    localparam int SW   = 8;
    localparam int SLAT = 1 + (SW + 3) * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (defaults)
    logic         reset_n, cmd_valid, cmd_ready, rsp_valid, tck, tdi, tdo;
    logic [1:0]   cmd_ir, rsp_ir, ir_in, ir_out, cur_ir;
    logic [W-1:0] cmd_dr, rsp_dr;
    logic         vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti;

    cpu_nios_debug_jtag_host #(.DR_WIDTH(W), .TCK_DIV(D)) u_dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_dr(rsp_dr),
        .rsp_ir(rsp_ir), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr),
        .jtag_state_rti(rti)
    );

    // loopback target: shifts tdi in on rising tck while in Shift-DR
    logic [W-1:0] tgt, load_val;
    logic         load_req = 1'b0;
    always @(posedge tck or posedge load_req)
        if (load_req) tgt <= load_val;
        else if (vs_sdr) tgt <= {tdi, tgt[W-1:1]};
    assign tdo    = tgt[0];
    assign ir_out = vs_uir ? cur_ir : ~cur_ir;

    // small DUT (DR_WIDTH=8, TCK_DIV=1)
    logic          s_reset_n, s_cmd_valid, s_cmd_ready, s_rsp_valid, s_tck, s_tdi, s_tdo;
    logic [1:0]    s_rsp_ir, s_ir_in;
    logic [SW-1:0] s_cmd_dr, s_rsp_dr;
    logic          s_uir, s_cdr, s_sdr, s_e1dr, s_rti;

    cpu_nios_debug_jtag_host #(.DR_WIDTH(SW), .TCK_DIV(1)) u_small (
        .clk(clk), .reset_n(s_reset_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_ir(2'b01), .cmd_dr(s_cmd_dr), .rsp_valid(s_rsp_valid), .rsp_dr(s_rsp_dr),
        .rsp_ir(s_rsp_ir), .tck(s_tck), .tdi(s_tdi), .tdo(s_tdo), .ir_in(s_ir_in),
        .ir_out(2'b10), .vs_uir(s_uir), .vs_cdr(s_cdr), .vs_sdr(s_sdr), .vs_e1dr(s_e1dr),
        .jtag_state_rti(s_rti)
    );

    logic [SW-1:0] s_tgt, s_load_val;
    logic          s_load_req = 1'b0;
    always @(posedge s_tck or posedge s_load_req)
        if (s_load_req) s_tgt <= s_load_val;
        else if (s_sdr) s_tgt <= {s_tdi, s_tgt[SW-1:1]};
    assign s_tdo = s_tgt[0];

    // scoreboards
    typedef struct {
        logic [W-1:0] dr;
        logic [W-1:0] after;
        logic [1:0]   ir;
        logic [1:0]   iri;
        int           t;
    } exp_t;
    typedef struct {
        logic [SW-1:0] dr;
        logic [SW-1:0] after;
        int            t;
    } sexp_t;

    exp_t  q[$];
    sexp_t sq[$];

    logic [W-1:0]  model_tgt;
    logic [SW-1:0] s_model;
    int drv_to = 0, s_to = 0;
    bit done = 0, s_done = 0;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input logic [W-1:0] v);
        load_val = v;
        load_req = 1'b1;
        #1 load_req = 1'b0;
        model_tgt = v;
    endtask

    task automatic send(input logic [1:0] ir, input logic [W-1:0] dr, input logic [1:0] iro, input bit hold);
        int n = 0;
        cmd_ir = ir;
        cmd_dr = dr;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            drv_to++;
            cmd_valid = 1'b0;
            return;
        end
        cur_ir = iro;
        q.push_back('{dr: model_tgt, after: dr, ir: iro, iri: ir, t: cyc});
        model_tgt = dr;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) drv_to++;
    endtask

    // main driver
    initial begin
        bit hold;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; cur_ir = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        load(38'h2A_5A5A_A5A5);
        send(2'd2, 38'h15_1234_5678, 2'd3, 1'b0);
        drain();

        send(2'($urandom), {6'($urandom), 32'($urandom)}, 2'($urandom), 1'b1);
        send(2'($urandom), 38'h3F_FFFF_FFFF, 2'($urandom), 1'b0);
        drain();

        send(2'd1, {6'($urandom), 32'($urandom)}, 2'd2, 1'b0);
        repeat (49) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dr = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        drain();

        send(2'd3, {6'($urandom), 32'($urandom)}, 2'd1, 1'b0);
        repeat (79) @(negedge clk);
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        load({6'($urandom), 32'($urandom)});
        send(2'd2, {6'($urandom), 32'($urandom)}, 2'd0, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) begin
            hold = (i < 7) && ($urandom_range(0, 1) == 1);
            send(2'($urandom), {6'($urandom), 32'($urandom)}, 2'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        done = 1;
    end

    // small-config driver
    initial begin
        logic [SW-1:0] dr;
        int n;
        s_reset_n = 1'b0; s_cmd_valid = 1'b0; s_cmd_dr = '0;
        repeat (3) @(negedge clk);
        s_reset_n = 1'b1;
        s_load_val = 8'h3C;
        s_load_req = 1'b1;
        #1 s_load_req = 1'b0;
        s_model = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            dr = (i == 0) ? 8'hA5 : 8'($urandom);
            s_cmd_dr = dr;
            s_cmd_valid = 1'b1;
            n = 0;
            while (!s_cmd_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!s_cmd_ready) s_to++;
            else begin
                sq.push_back('{dr: s_model, after: dr, t: cyc});
                s_model = dr;
            end
            @(negedge clk);
            s_cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n = 0;
        while (sq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) s_to++;
        s_done = 1;
    end

    // monitor
    initial begin
        exp_t  e;
        sexp_t se;
        bit rst_prev = 1, s_busy_prev = 0, s_tck_prev = 0;
        int code, prev_code = 0, run = 0, guard = 0;
        logic [W-1:0] last_rsp = '0;
        while (!(done && s_done && q.size() == 0 && sq.size() == 0) && guard < 60000) begin
            @(negedge clk);
            #1;
            guard++;
            if (rst_prev) begin
                chk("rst_ready", cmd_ready == 1'b1, 64'(cmd_ready), 64'd1);
                chk("rst_rti", rti == 1'b1, 64'(rti), 64'd1);
                chk("rst_tck_tdi", {tck, tdi} == 2'b00, 64'({tck, tdi}), 64'd0);
                chk("rst_vs", {vs_uir, vs_cdr, vs_sdr, vs_e1dr} == 4'b0, 64'({vs_uir, vs_cdr, vs_sdr, vs_e1dr}), 64'd0);
                chk("rst_rsp", {rsp_valid, rsp_ir, ir_in} == 5'b0, 64'({rsp_valid, rsp_ir, ir_in}), 64'd0);
                chk("rst_rsp_dr", rsp_dr == '0, 64'(rsp_dr), 64'd0);
            end
            chk("onehot", $countones({rti, vs_uir, vs_cdr, vs_sdr, vs_e1dr}) == 1,
                64'({rti, vs_uir, vs_cdr, vs_sdr, vs_e1dr}), 64'd1);
            if (cmd_ready) chk("idle_tck", tck == 1'b0, 64'(tck), 64'd0);

            code = rti ? 0 : vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : 4;
            if (code != prev_code) begin
                if (!rst_prev) begin
                    chk("strobe_order", code == ((prev_code == 4) ? 0 : prev_code + 1), 64'(code), 64'(prev_code));
                    if (prev_code == 1 || prev_code == 2 || prev_code == 4)
                        chk("strobe_len", run == 2 * D, 64'(run), 64'(2 * D));
                    if (prev_code == 3)
                        chk("sdr_len", run == W * 2 * D, 64'(run), 64'(W * 2 * D));
                end
                run = 1;
                prev_code = code;
            end else begin
                run++;
            end

            if (rsp_valid) begin
                chk("rsp_expected", q.size() != 0, 64'(q.size()), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_dr", rsp_dr == e.dr, 64'(rsp_dr), 64'(e.dr));
                    chk("rsp_ir", rsp_ir == e.ir, 64'(rsp_ir), 64'(e.ir));
                    chk("rsp_latency", cyc - e.t == LAT, 64'(cyc - e.t), 64'(LAT));
                    chk("target_after", tgt == e.after, 64'(tgt), 64'(e.after));
                    chk("ir_in_held", ir_in == e.iri, 64'(ir_in), 64'(e.iri));
                    last_rsp = e.dr;
                end
            end else if (!rst_prev) begin
                chk("rsp_hold", rsp_dr == last_rsp, 64'(rsp_dr), 64'(last_rsp));
            end
            if (!reset_n) last_rsp = '0;
            rst_prev = !reset_n;

            if (s_rsp_valid) begin
                chk("s_rsp_expected", sq.size() != 0, 64'(sq.size()), 64'd1);
                if (sq.size() != 0) begin
                    se = sq.pop_front();
                    chk("s_rsp_dr", s_rsp_dr == se.dr, 64'(s_rsp_dr), 64'(se.dr));
                    chk("s_rsp_latency", cyc - se.t == SLAT, 64'(cyc - se.t), 64'(SLAT));
                    chk("s_target_after", s_tgt == se.after, 64'(s_tgt), 64'(se.after));
                end
            end
            if (s_busy_prev && !s_cmd_ready)
                chk("s_tck_toggle", s_tck != s_tck_prev, 64'(s_tck), 64'(!s_tck_prev));
            s_busy_prev = !s_cmd_ready;
            s_tck_prev = s_tck;
        end
        chk("drain", done && s_done && q.size() == 0 && sq.size() == 0, 64'(q.size() + sq.size()), 64'd0);
        chk("drv_timeout", drv_to == 0 && s_to == 0, 64'(drv_to + s_to), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
